gated_pulse_counter: RTL and testbench

//  Consumes the single-cycle shaped photon pulses produced by the channel pulse shapers
//  (one per detector channel, 500 MHz domain).

---
 rtl/gated_pulse_counter.sv | 188 ++++++++++++++++++
 tb/tb_gated_pulse_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gated_pulse_counter.sv
`default_nettype none
//============================================================================
// Module      : gated_pulse_counter
// Description : Receiving end of the shaped-pulse interface. Over a
//               programmable integration gate it counts single-cycle pulses
//               on channel A and on channel B, and A/B coincidences within a
//               short window. It then holds the three counts for a
//               valid/ready readout.
// Ports       : clk       - system clock (500 MHz)
//               rst       - synchronous reset, active-high
//               pulse_a   - shaped pulse, channel A (1 cycle per event)
//               pulse_b   - shaped pulse, channel B (1 cycle per event)
//               start     - 1-cycle gate request, sampled only in IDLE
//               gate_len  - gate length in cycles, latched on accepted start
//               busy      - high while counting or holding results
//               valid     - results available
//               ready     - consumer accepts results when valid && ready
//               count_a   - channel A pulses in gate (saturating)
//               count_b   - channel B pulses in gate (saturating)
//               count_ab  - coincidences in gate (saturating)
//               overflow  - any counter saturated during this gate
// Revision    : 1.0 - initial release
//============================================================================
module gated_pulse_counter #(
    parameter int CNT_W     = 32,
    parameter int GATE_W    = 32,
    parameter int COINC_CYC = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_a,
    input  logic              pulse_b,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              valid,
    input  logic              ready,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b,
    output logic [CNT_W-1:0]  count_ab,
    output logic              overflow
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_COUNT = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    // A timer armed in cycle t is seen nonzero in cycles t+1 .. t+COINC_CYC-1,
    // so the window covers separations 0 .. COINC_CYC-1 cycles; a partner
    // arriving exactly COINC_CYC cycles later falls outside it.
    localparam logic [3:0] c_TMR_LOAD = 4'(COINC_CYC - 1);

    logic [1:0]        r_state;
    logic [GATE_W-1:0] r_remain;
    logic              r_busy;
    logic              r_valid;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_count_a;
    logic [CNT_W-1:0]  r_count_b;
    logic [CNT_W-1:0]  r_count_ab;
    logic [3:0]        r_tmr_a;
    logic [3:0]        r_tmr_b;

    logic              w_ab_hit;
    logic [3:0]        w_tmr_a_nxt;
    logic [3:0]        w_tmr_b_nxt;
    logic              w_sat_a;
    logic              w_sat_b;
    logic              w_sat_ab;
    logic              w_ovf_hit;

    // Coincidence pairing. Priority order guarantees each pulse joins at most
    // one coincidence: a pulse that consumes the partner's timer is not armed.
    always_comb begin
        w_ab_hit    = 1'b0;
        w_tmr_a_nxt = (r_tmr_a != 4'd0) ? (r_tmr_a - 4'd1) : 4'd0;
        w_tmr_b_nxt = (r_tmr_b != 4'd0) ? (r_tmr_b - 4'd1) : 4'd0;
        if (pulse_a && pulse_b) begin
            w_ab_hit    = 1'b1;
            w_tmr_a_nxt = 4'd0;
            w_tmr_b_nxt = 4'd0;
        end else if (pulse_a && (r_tmr_b != 4'd0)) begin
            w_ab_hit    = 1'b1;
            w_tmr_b_nxt = 4'd0;
        end else if (pulse_b && (r_tmr_a != 4'd0)) begin
            w_ab_hit    = 1'b1;
            w_tmr_a_nxt = 4'd0;
        end else begin
            if (pulse_a) begin
                w_tmr_a_nxt = c_TMR_LOAD;
            end
            if (pulse_b) begin
                w_tmr_b_nxt = c_TMR_LOAD;
            end
        end
    end

    // An increment attempted on an all-ones counter is the saturation event.
    always_comb begin
        w_sat_a   = pulse_a  && (&r_count_a);
        w_sat_b   = pulse_b  && (&r_count_b);
        w_sat_ab  = w_ab_hit && (&r_count_ab);
        w_ovf_hit = w_sat_a || w_sat_b || w_sat_ab;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_remain   <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_count_a  <= '0;
            r_count_b  <= '0;
            r_count_ab <= '0;
            r_tmr_a    <= 4'd0;
            r_tmr_b    <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_remain   <= gate_len;
                        r_overflow <= 1'b0;
                        r_count_a  <= '0;
                        r_count_b  <= '0;
                        r_count_ab <= '0;
                        r_tmr_a    <= 4'd0;
                        r_tmr_b    <= 4'd0;
                        r_busy     <= 1'b1;
                        if (gate_len != '0) begin
                            r_state <= c_COUNT;
                        end else begin
                            // Zero-length gate: report empty results at once.
                            r_state <= c_HOLD;
                            r_valid <= 1'b1;
                        end
                    end
                end

                c_COUNT: begin
                    if (pulse_a && !w_sat_a) begin
                        r_count_a <= r_count_a + 1'b1;
                    end
                    if (pulse_b && !w_sat_b) begin
                        r_count_b <= r_count_b + 1'b1;
                    end
                    if (w_ab_hit && !w_sat_ab) begin
                        r_count_ab <= r_count_ab + 1'b1;
                    end
                    r_overflow <= r_overflow | w_ovf_hit;
                    r_tmr_a    <= w_tmr_a_nxt;
                    r_tmr_b    <= w_tmr_b_nxt;
                    // r_remain counts the COUNT cycles still to sample,
                    // including the current one.
                    if (r_remain == GATE_W'(1)) begin
                        r_state <= c_HOLD;
                        r_valid <= 1'b1;
                    end else begin
                        r_remain <= r_remain - 1'b1;
                    end
                end

                c_HOLD: begin
                    if (ready) begin
                        r_state <= c_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign overflow = r_overflow;
    assign count_a  = r_count_a;
    assign count_b  = r_count_b;
    assign count_ab = r_count_ab;

endmodule
`default_nettype wire

// File: tb/tb_gated_pulse_counter.sv
`default_nettype none
//============================================================================
// Module      : tb_gated_pulse_counter
// Description : Directed self-checking bench for gated_pulse_counter. Two
//               instances share all inputs: a full-width one and a 4-bit
//               counter one for saturation behaviour.
// Revision    : 1.0 - initial release
//============================================================================
module tb_gated_pulse_counter;

    logic        clk;
    logic        rst;
    logic        pulse_a;
    logic        pulse_b;
    logic        start;
    logic [31:0] gate_len;
    logic        ready;

    logic        busy;
    logic        valid;
    logic [31:0] count_a;
    logic [31:0] count_b;
    logic [31:0] count_ab;
    logic        overflow;

    logic        s_busy;
    logic        s_valid;
    logic [3:0]  s_count_a;
    logic [3:0]  s_count_b;
    logic [3:0]  s_count_ab;
    logic        s_overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle stimulus masks for one gate (bit index = cycle number).
    bit [127:0] pa;
    bit [127:0] pb;
    bit [127:0] st;

    gated_pulse_counter #(.CNT_W(32), .GATE_W(32), .COINC_CYC(5)) u_dut (
        .clk(clk), .rst(rst), .pulse_a(pulse_a), .pulse_b(pulse_b),
        .start(start), .gate_len(gate_len), .busy(busy), .valid(valid),
        .ready(ready), .count_a(count_a), .count_b(count_b),
        .count_ab(count_ab), .overflow(overflow)
    );

    gated_pulse_counter #(.CNT_W(4), .GATE_W(32), .COINC_CYC(5)) u_dut_small (
        .clk(clk), .rst(rst), .pulse_a(pulse_a), .pulse_b(pulse_b),
        .start(start), .gate_len(gate_len), .busy(s_busy), .valid(s_valid),
        .ready(ready), .count_a(s_count_a), .count_b(s_count_b),
        .count_ab(s_count_ab), .overflow(s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one gate of n cycles; start with gate_len=glen in cycle 0. Returns
    // in cycle n+2 after driving the cycle-(n+1) pulses (which must be ignored).
    task automatic run_gate(input string tag, input int n, input logic [31:0] glen);
        int busy_cnt = 0;
        int early_valid = 0;
        for (int cyc = 0; cyc <= n; cyc++) begin
            start    = (cyc == 0) || st[cyc];
            gate_len = (cyc == 0) ? glen : 32'd3;
            pulse_a  = pa[cyc];
            pulse_b  = pb[cyc];
            tick();
            if (busy) busy_cnt++;
            if (valid && (cyc < n)) early_valid++;
        end
        start   = 1'b0;
        pulse_a = pa[n+1];
        pulse_b = pb[n+1];
        check({tag, "_valid_rise"}, 32'(valid), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n + 1));
        check({tag, "_early_valid"}, 32'(early_valid), 32'd0);
        tick();
        pulse_a = 1'b0;
        pulse_b = 1'b0;
        pa = '0;
        pb = '0;
        st = '0;
    endtask

    task automatic handshake(input string tag);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(valid), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; pulse_a = 1'b0; pulse_b = 1'b0; start = 1'b0;
        gate_len = 32'd0; ready = 1'b0;
        pa = '0; pb = '0; st = '0;

        // Reset state.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_cnt_a", count_a, 32'd0);
        check("rst_cnt_ab", count_ab, 32'd0);
        rst = 1'b0;
        tick();

        // 1: empty gate of 100 cycles.
        run_gate("t1", 100, 32'd100);
        check("t1_cnt_a", count_a, 32'd0);
        check("t1_cnt_b", count_b, 32'd0);
        check("t1_cnt_ab", count_ab, 32'd0);
        check("t1_ovf", 32'(overflow), 32'd0);
        handshake("t1");

        // 2: separated singles, no coincidences.
        pa[3] = 1; pa[10] = 1; pa[20] = 1;
        pb[40] = 1; pb[45] = 1;
        run_gate("t2", 50, 32'd50);
        check("t2_cnt_a", count_a, 32'd3);
        check("t2_cnt_b", count_b, 32'd2);
        check("t2_cnt_ab", count_ab, 32'd0);
        handshake("t2");

        // 3: coincidence window and single use of each pulse.
        pa[10] = 1; pb[10] = 1;
        pa[20] = 1; pb[24] = 1;
        pa[30] = 1; pb[35] = 1;
        pb[60] = 1; pa[62] = 1; pa[63] = 1;
        run_gate("t3", 70, 32'd70);
        check("t3_cnt_a", count_a, 32'd5);
        check("t3_cnt_b", count_b, 32'd4);
        check("t3_cnt_ab", count_ab, 32'd3);
        handshake("t3");

        // 4: pulses at cycle 0 and N+1 ignored; start mid-gate ignored.
        pa[0] = 1; pa[5] = 1; pa[11] = 1;
        pb[0] = 1; pb[11] = 1;
        st[5] = 1;
        run_gate("t4", 10, 32'd10);
        check("t4_cnt_a", count_a, 32'd1);
        check("t4_cnt_b", count_b, 32'd0);
        check("t4_cnt_ab", count_ab, 32'd0);
        handshake("t4");

        // Zero-length gate goes straight to results.
        run_gate("t0len", 0, 32'd0);
        check("t0len_cnt_a", count_a, 32'd0);
        handshake("t0len");

        // 5: saturation on the 4-bit instance.
        for (int i = 1; i <= 20; i++) pa[i] = 1;
        run_gate("t5", 25, 32'd25);
        check("t5_cnt_a", count_a, 32'd20);
        check("t5_ovf", 32'(overflow), 32'd0);
        check("t5_small_cnt_a", 32'(s_count_a), 32'd15);
        check("t5_small_ovf", 32'(s_overflow), 32'd1);
        handshake("t5");

        // 6: results held while ready is low; overflow cleared by new gate.
        pa[2] = 1; pb[4] = 1;
        run_gate("t6", 8, 32'd8);
        for (int i = 0; i < 10; i++) tick();
        check("t6_hold_valid", 32'(valid), 32'd1);
        check("t6_hold_busy", 32'(busy), 32'd1);
        check("t6_hold_cnt_a", count_a, 32'd1);
        check("t6_hold_cnt_b", count_b, 32'd1);
        check("t6_hold_cnt_ab", count_ab, 32'd1);
        check("t6_small_ovf", 32'(s_overflow), 32'd0);
        handshake("t6");

        // Reset in the middle of a gate discards it.
        start = 1'b1; gate_len = 32'd50;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            pulse_a = (i <= 5);
            tick();
        end
        pulse_a = 1'b0;
        rst = 1'b1;
        tick();
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_valid", 32'(valid), 32'd0);
        check("rstmid_cnt_a", count_a, 32'd0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
